// File: rtl/alu_operand_issue.sv
// Operand issue stage: three operand FIFOs feed aligned triples to the ALU for a
// counted batch. Output triples are registered; Start/Done bracket each batch.
`ifndef ALU_CFG_BITS
`define ALU_CFG_BITS 4
`endif

module alu_operand_issue #(
  parameter int                  WORD_BITS = 16,
  parameter int                  CFG_BITS  = `ALU_CFG_BITS,
  parameter int                  DEPTH     = 4,
  parameter logic [CFG_BITS-1:0] EXE_NOP   = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 En_in,
  input  logic                 Start_in,
  input  logic [CFG_BITS-1:0]  CFG_in,
  input  logic [7:0]           Cnt_in,
  input  logic                 A0_valid_in,
  input  logic [WORD_BITS-1:0] A0_in,
  output logic                 A0_ready_out,
  input  logic                 A1_valid_in,
  input  logic [WORD_BITS-1:0] A1_in,
  output logic                 A1_ready_out,
  input  logic                 A2_valid_in,
  input  logic [WORD_BITS-1:0] A2_in,
  output logic                 A2_ready_out,
  output logic [CFG_BITS-1:0]  CFG_out,
  output logic                 S0_valid_out,
  output logic [WORD_BITS-1:0] S0_out,
  output logic                 S1_valid_out,
  output logic [WORD_BITS-1:0] S1_out,
  output logic                 S2_valid_out,
  output logic [WORD_BITS-1:0] S2_out,
  output logic                 Busy_out,
  output logic                 Done_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [CFG_BITS-1:0] cfg_q;

  logic [2:0]           a_valid;
  logic [WORD_BITS-1:0] a_data [3];
  logic [WORD_BITS-1:0] mem_q  [3][DEPTH];
  logic [AW:0]          wr_ptr_q [3];
  logic [AW:0]          wr_ptr_d [3];
  logic [AW:0]          rd_ptr_q [3];
  logic [AW:0]          rd_ptr_d [3];
  logic [AW:0]          occ      [3];
  logic [WORD_BITS-1:0] head     [3];
  logic [2:0]           ready;
  logic [2:0]           push;
  logic [2:0]           not_empty;
  logic                 issue;

  logic                 s_valid_q;
  logic [WORD_BITS-1:0] s_q [3];
  logic [CFG_BITS-1:0]  cfg_out_q;

  assign a_valid   = {A2_valid_in, A1_valid_in, A0_valid_in};
  assign a_data[0] = A0_in;
  assign a_data[1] = A1_in;
  assign a_data[2] = A2_in;

  // Pointers carry one extra bit so full and empty differ when the low bits match.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      occ[k]       = wr_ptr_q[k] - rd_ptr_q[k];
      ready[k]     = occ[k] < (AW+1)'(DEPTH);
      push[k]      = a_valid[k] & ready[k];
      not_empty[k] = occ[k] != '0;
      head[k]      = mem_q[k][rd_ptr_q[k][AW-1:0]];
    end
  end

  assign issue = (state_q == ST_RUN) && En_in && (&not_empty);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + 1'b1 : wr_ptr_q[k];
      rd_ptr_d[k] = issue   ? rd_ptr_q[k] + 1'b1 : rd_ptr_q[k];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= a_data[k];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cfg_q   <= EXE_NOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_in) begin
            cfg_q   <= CFG_in;
            cnt_q   <= Cnt_in;
            state_q <= (Cnt_in != 8'd0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (issue) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data registers hold their last triple between issues; only valid/opcode fall back.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_valid_q <= 1'b0;
      cfg_out_q <= EXE_NOP;
      for (int k = 0; k < 3; k++) s_q[k] <= '0;
    end else if (issue) begin
      s_valid_q <= 1'b1;
      cfg_out_q <= cfg_q;
      for (int k = 0; k < 3; k++) s_q[k] <= head[k];
    end else begin
      s_valid_q <= 1'b0;
      cfg_out_q <= EXE_NOP;
    end
  end

  assign A0_ready_out = ready[0];
  assign A1_ready_out = ready[1];
  assign A2_ready_out = ready[2];
  assign CFG_out      = cfg_out_q;
  assign S0_valid_out = s_valid_q;
  assign S1_valid_out = s_valid_q;
  assign S2_valid_out = s_valid_q;
  assign S0_out       = s_q[0];
  assign S1_out       = s_q[1];
  assign S2_out       = s_q[2];
  assign Busy_out     = state_q != ST_IDLE;
  assign Done_out     = state_q == ST_DONE;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: queue-based reference model feeds a scoreboard that
// a negedge monitor drains whenever the DUT presents a triple.
module tb_alu_operand_issue;
  localparam int W  = 16;
  localparam int CB = 4;
  localparam int D  = 4;
  localparam logic [CB-1:0] EXE_NOP = 4'h0;
  localparam logic [CB-1:0] EXE_ADD = 4'h1;
  localparam logic [CB-1:0] EXE_MAC = 4'h2;

  logic          CLK = 1'b0, RST = 1'b0, En_in = 1'b0, Start_in = 1'b0;
  logic [CB-1:0] CFG_in = '0;
  logic [7:0]    Cnt_in = '0;
  logic [2:0]    av = '0;
  logic [W-1:0]  ad0 = '0, ad1 = '0, ad2 = '0;
  logic          r0, r1, r2, v0, v1, v2, busy, done;
  logic [W-1:0]  s0, s1, s2;
  logic [CB-1:0] cfg_o;

  alu_operand_issue #(.WORD_BITS(W), .CFG_BITS(CB), .DEPTH(D), .EXE_NOP(EXE_NOP)) dut (
    .CLK(CLK), .RST(RST), .En_in(En_in), .Start_in(Start_in), .CFG_in(CFG_in), .Cnt_in(Cnt_in),
    .A0_valid_in(av[0]), .A0_in(ad0), .A0_ready_out(r0),
    .A1_valid_in(av[1]), .A1_in(ad1), .A1_ready_out(r1),
    .A2_valid_in(av[2]), .A2_in(ad2), .A2_ready_out(r2),
    .CFG_out(cfg_o), .S0_valid_out(v0), .S0_out(s0), .S1_valid_out(v1), .S1_out(s1),
    .S2_valid_out(v2), .S2_out(s2), .Busy_out(busy), .Done_out(done));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, batch as phase + remaining count.
  typedef struct { logic [W-1:0] a0, a1, a2; logic [CB-1:0] cfg; } exp_t;
  logic [W-1:0]  mq0[$], mq1[$], mq2[$];
  exp_t          sb[$];
  int            m_phase = 0;   // 0 idle, 1 running, 2 done
  int            m_rem   = 0;
  logic [CB-1:0] m_cfg   = EXE_NOP;
  logic          m_issue = 1'b0;
  logic [W-1:0]  m_last0 = '0, m_last1 = '0, m_last2 = '0;

  task automatic model_clear();
    mq0.delete(); mq1.delete(); mq2.delete(); sb.delete();
    m_phase = 0; m_rem = 0; m_issue = 1'b0;
    m_last0 = '0; m_last1 = '0; m_last2 = '0;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      automatic int  z0 = mq0.size();
      automatic int  z1 = mq1.size();
      automatic int  z2 = mq2.size();
      automatic bit  iss = (m_phase == 1) && En_in && z0 > 0 && z1 > 0 && z2 > 0;
      automatic exp_t e;
      if (av[0] && z0 < D) mq0.push_back(ad0);
      if (av[1] && z1 < D) mq1.push_back(ad1);
      if (av[2] && z2 < D) mq2.push_back(ad2);
      if (iss) begin
        e.a0 = mq0.pop_front(); e.a1 = mq1.pop_front(); e.a2 = mq2.pop_front();
        e.cfg = m_cfg;
        sb.push_back(e);
        m_last0 = e.a0; m_last1 = e.a1; m_last2 = e.a2;
      end
      m_issue = iss;
      if (m_phase == 0) begin
        if (Start_in) begin
          m_cfg = CFG_in;
          m_rem = Cnt_in;
          m_phase = (Cnt_in == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (iss) begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      automatic exp_t e;
      chk("s0_valid", {31'b0, v0}, {31'b0, m_issue});
      chk("s1_valid", {31'b0, v1}, {31'b0, v0});
      chk("s2_valid", {31'b0, v2}, {31'b0, v0});
      if (v0) begin
        if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk("triple_s0", {16'b0, s0}, {16'b0, e.a0});
          chk("triple_s1", {16'b0, s1}, {16'b0, e.a1});
          chk("triple_s2", {16'b0, s2}, {16'b0, e.a2});
          chk("triple_cfg", {28'b0, cfg_o}, {28'b0, e.cfg});
        end
      end else begin
        chk("cfg_nop", {28'b0, cfg_o}, {28'b0, EXE_NOP});
        chk("hold_s0", {16'b0, s0}, {16'b0, m_last0});
        chk("hold_s1", {16'b0, s1}, {16'b0, m_last1});
        chk("hold_s2", {16'b0, s2}, {16'b0, m_last2});
      end
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("done", {31'b0, done}, {31'b0, m_phase == 2});
      chk("ready0", {31'b0, r0}, {31'b0, mq0.size() < D});
      chk("ready1", {31'b0, r1}, {31'b0, mq1.size() < D});
      chk("ready2", {31'b0, r2}, {31'b0, mq2.size() < D});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic push3(input logic [2:0] m, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2);
    av = m; ad0 = d0; ad1 = d1; ad2 = d2;
    tick();
    av = '0;
  endtask

  task automatic start(input logic [CB-1:0] c, input logic [7:0] n);
    Start_in = 1'b1; CFG_in = c; Cnt_in = n;
    tick();
    Start_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {29'b0, v2, v1, v0}, 32'd0);
    chk({tag, "_s"}, {s0 | s1 | s2}, 32'd0);
    chk({tag, "_cfg"}, {28'b0, cfg_o}, {28'b0, EXE_NOP});
    chk({tag, "_busy_done"}, {30'b0, busy, done}, 32'd0);
    chk({tag, "_ready"}, {29'b0, r2, r1, r0}, 32'd7);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("rst_now");
    tick(2);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_after");
  endtask

  initial begin
    #2;
    check_reset_outputs("rst_init");
    tick();
    RST = 1'b1;
    En_in = 1'b1;

    // Single ADD triple of Q9.6 values
    push3(3'b111, 16'hFAE0, 16'hFAE0, 16'h00A0);
    start(EXE_ADD, 8'd1);
    tick(3);

    // MAC batch waiting on an empty third source
    for (int i = 0; i < 3; i++) push3(3'b011, W'(16'h0100 + i), W'(16'h0200 + i), 16'h0);
    start(EXE_MAC, 8'd3);
    tick(3);
    for (int i = 0; i < 3; i++) push3(3'b100, 16'h0, 16'h0, 16'hFFA0);
    tick(4);

    // Overfill one source; the fifth word is dropped
    for (int i = 1; i <= 5; i++) push3(3'b001, W'(i), 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) push3(3'b110, 16'h0, W'(16'h1000 + i), W'(16'h2000 + i));
    start(EXE_ADD, 8'd4);
    tick(6);

    // Empty batch, plus a start while busy
    start(EXE_MAC, 8'd0);
    start(EXE_ADD, 8'd2);
    tick(3);

    // Stall with all FIFOs non-empty
    for (int i = 0; i < 4; i++) push3(3'b111, W'(16'h3000 + i), W'(16'h4000 + i), W'(16'h5000 + i));
    En_in = 1'b0;
    start(EXE_MAC, 8'd4);
    tick(3);
    En_in = 1'b1;
    tick(6);

    // Reset in the middle of a batch with two triples left
    for (int i = 0; i < 4; i++) push3(3'b111, W'(16'h6000 + i), W'(16'h7000 + i), W'(16'h8000 + i));
    start(EXE_ADD, 8'd4);
    tick(2);
    do_reset();
    tick(5);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      av = 3'($urandom_range(0, 7));
      ad0 = W'($urandom); ad1 = W'($urandom); ad2 = W'($urandom);
      En_in = ($urandom_range(0, 9) < 8);
      Start_in = ($urandom_range(0, 7) == 0);
      CFG_in = CB'($urandom_range(1, 15));
      Cnt_in = 8'($urandom_range(0, 6));
      tick();
    end
    av = '0; Start_in = 1'b0; En_in = 1'b1;
    tick(3);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
